// File: rtl/usb_tx_nrzi.sv
// usb_tx_nrzi: full-speed USB line transmitter (48 MHz clock, 4 clocks per bit).
// It takes packet bytes over a valid/ready handshake and sends them LSB first.
// The line sequence is SYNC, the data bytes with bit stuffing, then EOP.
// The bit stream is NRZI-encoded onto vp/vm, and oe is held high for the whole packet.
//
// Ports:
//   c_48      in   48 MHz clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   d[7:0]    in   packet byte, sent LSB first
//   d_last    in   marks the final byte of the packet
//   dv        in   byte valid
//   rdy       out  holding buffer empty; byte taken on dv & rdy
//   vp, vm    out  line state: J = 10, K = 01, SE0 = 00 (registered)
//   oe        out  transceiver drive enable (registered)
//   busy      out  packet in progress, SYNC through EOP J bit
//   underrun  out  one-cycle pulse when a byte was needed but none buffered
module usb_tx_nrzi (
   input  logic       c_48,
   input  logic       rst_n,
   input  logic [7:0] d,
   input  logic       d_last,
   input  logic       dv,
   output logic       rdy,
   output logic       vp,
   output logic       vm,
   output logic       oe,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StData,
      StStuff,
      StEopSe0,
      StEopJ
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  sr_q, sr_d;
   logic [2:0]  idx_q, idx_d;
   logic        sr_last_q, sr_last_d;
   logic [2:0]  ones_q, ones_d;
   logic [7:0]  buf_q, buf_d;
   logic        buf_last_q, buf_last_d;
   logic        buf_full_q, buf_full_d;
   logic        last_acc_q, last_acc_d;
   logic        abort_q, abort_d;
   logic        vp_q, vp_d;
   logic        vm_q, vm_d;
   logic        oe_q, oe_d;
   logic        underrun_q, underrun_d;

   logic        boundary;
   logic        unload;
   logic        emit;
   logic        bit_val;
   logic        eop_end;
   logic        accept;
   logic        keep;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      idx_d      = idx_q;
      sr_last_d  = sr_last_q;
      ones_d     = ones_q;
      vp_d       = vp_q;
      vm_d       = vm_q;
      oe_d       = oe_q;
      underrun_d = 1'b0;
      abort_d    = abort_q;
      unload     = 1'b0;
      emit       = 1'b0;
      bit_val    = 1'b0;
      eop_end    = 1'b0;
      boundary   = (cnt_q == 2'd3);

      case (state_q)
         StIdle: begin
            cnt_d   = 2'd0;
            oe_d    = 1'b0;
            vp_d    = 1'b1;
            vm_d    = 1'b0;
            abort_d = 1'b0;
            if (buf_full_q) begin
               // SYNC is 0x80 LSB first; its first bit (0) goes out on this edge.
               state_d = StSync;
               sr_d    = 8'h80;
               idx_d   = 3'd0;
               oe_d    = 1'b1;
               emit    = 1'b1;
               bit_val = 1'b0;
            end
         end
         StSync, StData, StStuff: begin
            cnt_d = cnt_q + 2'd1;
            if (boundary) begin
               if (ones_q == 3'd6) begin
                  // Six ones in a row: insert a stuffed 0, shift register holds.
                  state_d = StStuff;
                  emit    = 1'b1;
                  bit_val = 1'b0;
               end else if (idx_q != 3'd7) begin
                  state_d = (state_q == StSync) ? StSync : StData;
                  sr_d    = sr_q >> 1;
                  idx_d   = idx_q + 3'd1;
                  emit    = 1'b1;
                  bit_val = sr_q[1];
               end else if (state_q == StSync || (!sr_last_q && buf_full_q)) begin
                  // Byte boundary: the buffer is guaranteed full at the end of SYNC.
                  state_d   = StData;
                  sr_d      = buf_q;
                  sr_last_d = buf_last_q;
                  idx_d     = 3'd0;
                  unload    = 1'b1;
                  emit      = 1'b1;
                  bit_val   = buf_q[0];
               end else begin
                  state_d    = StEopSe0;
                  idx_d      = 3'd0;
                  vp_d       = 1'b0;
                  vm_d       = 1'b0;
                  underrun_d = ~sr_last_q;
                  abort_d    = ~sr_last_q;
               end
            end
         end
         StEopSe0: begin
            cnt_d = cnt_q + 2'd1;
            vp_d  = 1'b0;
            vm_d  = 1'b0;
            if (boundary) begin
               // idx counts the two SE0 bit times.
               if (idx_q == 3'd0) begin
                  idx_d = 3'd1;
               end else begin
                  state_d = StEopJ;
                  vp_d    = 1'b1;
                  vm_d    = 1'b0;
               end
            end
         end
         StEopJ: begin
            cnt_d = cnt_q + 2'd1;
            if (boundary) begin
               state_d = StIdle;
               oe_d    = 1'b0;
               cnt_d   = 2'd0;
               eop_end = 1'b1;
               abort_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // NRZI: a 0 swaps J/K, a 1 holds the level.
      if (emit) begin
         if (!bit_val) begin
            vp_d = vm_q;
            vm_d = vp_q;
         end
         ones_d = bit_val ? ones_q + 3'd1 : 3'd0;
      end

      // The buffer reopens in the last EOP_J clock so a waiting byte lands
      // on the same edge that oe falls.
      rdy    = ~buf_full_q & (~last_acc_q | eop_end);
      accept = dv & rdy;
      keep   = accept & ~abort_d;

      buf_d      = buf_q;
      buf_last_d = buf_last_q;
      buf_full_d = buf_full_q;
      last_acc_d = last_acc_q;
      if (eop_end) begin
         last_acc_d = 1'b0;
      end
      if (unload) begin
         buf_full_d = 1'b0;
      end
      if (keep) begin
         buf_d      = d;
         buf_last_d = d_last;
         buf_full_d = 1'b1;
         if (d_last) begin
            last_acc_d = 1'b1;
         end
      end
   end

   always_ff @(posedge c_48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 2'd0;
         sr_q       <= 8'h00;
         idx_q      <= 3'd0;
         sr_last_q  <= 1'b0;
         ones_q     <= 3'd0;
         buf_q      <= 8'h00;
         buf_last_q <= 1'b0;
         buf_full_q <= 1'b0;
         last_acc_q <= 1'b0;
         abort_q    <= 1'b0;
         vp_q       <= 1'b1;
         vm_q       <= 1'b0;
         oe_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         idx_q      <= idx_d;
         sr_last_q  <= sr_last_d;
         ones_q     <= ones_d;
         buf_q      <= buf_d;
         buf_last_q <= buf_last_d;
         buf_full_q <= buf_full_d;
         last_acc_q <= last_acc_d;
         abort_q    <= abort_d;
         vp_q       <= vp_d;
         vm_q       <= vm_d;
         oe_q       <= oe_d;
         underrun_q <= underrun_d;
      end
   end

   assign vp       = vp_q;
   assign vm       = vm_q;
   assign oe       = oe_q;
   assign underrun = underrun_q;
   assign busy     = (state_q != StIdle);

endmodule
